// File: rtl/dinorun_pkg.sv
// Shared types, constants and helpers for the dinorun game logic.
package dinorun_pkg;

  // Game state shared with the renderers; 2'b11 is unused and recovers to STARTING.
  typedef logic [1:0] state_t;

  localparam state_t STARTING = 2'b00;
  localparam state_t PLAYING  = 2'b01;
  localparam state_t HIT      = 2'b10;

  localparam int          ScoreDigits = 4;
  localparam logic [15:0] ScoreMax    = 16'h9999;

  // Enables handed to the title, obstacle and motion logic.
  typedef struct packed {
    logic title_en;
    logic obstacle_en;
    logic freeze;
  } render_en_t;

  // Saturating BCD increment: 9 rolls to 0 and carries; 9999 stays 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] val);
    logic [15:0] res;
    logic        carry;
    res   = val;
    carry = 1'b1;
    if (val != ScoreMax) begin
      for (int i = 0; i < ScoreDigits; i++) begin
        if (carry) begin
          if (val[4*i +: 4] >= 4'd9) begin
            res[4*i +: 4] = 4'd0;
          end else begin
            res[4*i +: 4] = val[4*i +: 4] + 4'd1;
            carry         = 1'b0;
          end
        end
      end
    end
    return res;
  endfunction

  // Renderer enables that belong to a given state.
  function automatic render_en_t render_en(input state_t s);
    render_en_t r;
    r.title_en    = (s == STARTING);
    r.obstacle_en = (s == PLAYING) || (s == HIT);
    r.freeze      = (s == HIT);
    return r;
  endfunction

endpackage

// File: rtl/dinorun_bcd_score.sv
// Running score: frame divider plus saturating 4-digit BCD counter.
module dinorun_bcd_score
  import dinorun_pkg::*;
#(
  parameter int ScoreDivFrames = 6
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        tick_i,
  output logic [15:0] score_o
);

  localparam int DivW = (ScoreDivFrames > 1) ? $clog2(ScoreDivFrames) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(ScoreDivFrames - 1);

  logic [DivW-1:0] div_q, div_d;
  logic [15:0]     score_q, score_d;

  // Clear wins over tick; a tick on the last divider frame bumps the score.
  always_comb begin
    div_d   = div_q;
    score_d = score_q;
    if (clear_i) begin
      div_d   = '0;
      score_d = '0;
    end else if (tick_i) begin
      if (div_q == DivLast) begin
        div_d   = '0;
        score_d = bcd_inc(score_q);
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // Score and divider registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q   <= '0;
      score_q <= '0;
    end else begin
      div_q   <= div_d;
      score_q <= score_d;
    end
  end

  assign score_o = score_q;

endmodule

// File: rtl/dinorun_game_ctrl.sv
// Game sequencer: owns the game state, renderer enables, score and high score.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// STARTING | title screen, waiting for the first start press
// PLAYING  | game running, score counting, obstacles active
// HIT      | collision happened, scene frozen, restart after hold time
module dinorun_game_ctrl
  import dinorun_pkg::*;
#(
  parameter int ScoreDivFrames = 6,
  parameter int HitHoldFrames  = 60
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        next_frame_i,
  input  logic        start_i,
  input  logic        collision_i,
  output state_t      state_o,
  output logic        title_en_o,
  output logic        obstacle_en_o,
  output logic        obstacle_rst_o,
  output logic        freeze_o,
  output logic [15:0] score_o,
  output logic [15:0] high_score_o
);

  localparam int HoldW = $clog2(HitHoldFrames + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HitHoldFrames);

  state_t          state_q, state_d;
  logic            start_q;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [15:0]     high_q, high_d;
  render_en_t      en_q, en_d;
  logic            obs_rst_q;

  logic            start_rise;
  logic            enter_play;
  logic            score_tick;
  logic            score_clear;
  logic [15:0]     score_w;

  assign start_rise = start_i & ~start_q;

  // Next-state, hold counter and high-score capture.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    high_d     = high_q;
    enter_play = 1'b0;
    case (state_q)
      STARTING: begin
        if (start_rise) begin
          state_d    = PLAYING;
          enter_play = 1'b1;
        end
      end
      PLAYING: begin
        if (collision_i) begin
          state_d = HIT;
          hold_d  = '0;
          if (score_w > high_q) begin
            high_d = score_w;
          end
        end
      end
      HIT: begin
        if (start_rise && (hold_q == HoldMax)) begin
          state_d    = PLAYING;
          enter_play = 1'b1;
        end else if (next_frame_i && (hold_q != HoldMax)) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = STARTING;
      end
    endcase
  end

  // Collision suppresses the score tick of the same cycle.
  assign score_tick  = (state_q == PLAYING) & next_frame_i & ~collision_i;
  assign score_clear = enter_play | (state_q == STARTING);

  // Enables are decoded from the next state so they change with state_o.
  always_comb begin
    en_d = render_en(state_d);
  end

  // Control registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= STARTING;
      start_q   <= 1'b0;
      hold_q    <= '0;
      high_q    <= '0;
      en_q      <= render_en(STARTING);
      obs_rst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_i;
      hold_q    <= hold_d;
      high_q    <= high_d;
      en_q      <= en_d;
      obs_rst_q <= enter_play;
    end
  end

  dinorun_bcd_score #(
    .ScoreDivFrames(ScoreDivFrames)
  ) u_score (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(score_clear),
    .tick_i (score_tick),
    .score_o(score_w)
  );

  assign state_o        = state_q;
  assign title_en_o     = en_q.title_en;
  assign obstacle_en_o  = en_q.obstacle_en;
  assign freeze_o       = en_q.freeze;
  assign obstacle_rst_o = obs_rst_q;
  assign score_o        = score_w;
  assign high_score_o   = high_q;

endmodule
